// File: rtl/uart_recv.sv
// UART receiver for the 10-bit frame (start 0, 8 data bits MSB first, stop 1).
// The line is synchronised, then sampled mid-bit by counting oversample ticks.
//
// state | meaning
// IDLE  | line idle, waiting for a tick with the line low
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling eight data bits, one per bit period
// STOP  | sampling the stop bit, then publishing the byte or flagging an error
// BREAK | stop bit was low; waiting for the line to return high
module uart_recv #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       s_in,
    output logic [7:0] q_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_TC = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TC = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          s_sync;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    assign s_sync = sync[1];
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync      <= 2'b11;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            q_out     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // the synchroniser and the output pulses ignore clk_en
            sync      <= {sync[0], s_in};
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (clk_en) begin
                case (state)
                    IDLE: begin
                        if (!s_sync) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_TC) begin
                            if (!s_sync) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_TC) begin
                            shift_reg <= {shift_reg[6:0], s_sync};
                            tick_cnt  <= '0;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_TC) begin
                            tick_cnt <= '0;
                            // returning to IDLE at mid-stop leaves room for a back-to-back start
                            if (s_sync) begin
                                q_out <= shift_reg;
                                valid <= 1'b1;
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    BREAK: begin
                        if (s_sync) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: stimulus pushes expected events, a monitor pops them.
module tb_uart_recv;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       s_in;
    logic [7:0] q_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   last_valid_cyc = -1;
    int   prev_valid_cyc = -1;
    logic gate_en = 1'b0;
    logic pulse_pending = 1'b0;

    uart_recv #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .s_in      (s_in),
        .q_out     (q_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
        s_in = 1'b0;
        wait_clk(bclk);
        for (int i = 7; i >= 0; i--) begin
            s_in = d[i];
            wait_clk(bclk);
        end
        s_in = stop;
        wait_clk(bclk);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    // clk_en generator: every clk, or every third clk when gated
    initial begin
        int phase;
        phase  = 0;
        clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (gate_en) begin
                phase  = (phase + 1) % 3;
                clk_en = (phase == 0);
            end else begin
                clk_en = 1'b1;
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pulse_pending) begin
                check("pulse_width", 32'(valid | frame_err), 32'd0);
                pulse_pending = 1'b0;
            end else if (valid || frame_err) begin
                check("valid_ferr_exclusive", 32'(valid & frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_output: valid=%0b frame_err=%0b q_out=0x%0h, expected none (cyc %0d)",
                             valid, frame_err, q_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        check("frame_err_event", 32'(frame_err), 32'd1);
                    end else begin
                        check("valid_event", 32'(valid), 32'd1);
                        check("q_out_data", 32'(q_out), 32'(e.data));
                    end
                end
                if (valid) begin
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                end
                pulse_pending = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst  = 1'b1;
        s_in = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check("reset_q_out", 32'(q_out), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clk(20);

        // single frame 0xA5, latency from the falling edge
        expect_byte(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 16);
        wait_clk(32);
        check("a5_latency_ok", 32'((last_valid_cyc - t0 >= 153) && (last_valid_cyc - t0 <= 155)), 32'd1);
        check("a5_latency", 32'(last_valid_cyc - t0), 32'd155);

        // glitch: 4 clk low
        s_in = 1'b0;
        wait_clk(4);
        s_in = 1'b1;
        wait_clk(2);
        check("glitch_busy_high", 32'(busy), 32'd1);
        wait_clk(14);
        check("glitch_busy_dropped", 32'(busy), 32'd0);
        check("glitch_q_out_held", 32'(q_out), 32'hA5);
        wait_clk(32);

        // framing error followed by a held-low break
        expect_err();
        send_frame(8'h3C, 1'b0, 16);
        wait_clk(320);
        check("break_busy_high", 32'(busy), 32'd1);
        wait_clk(320);
        s_in = 1'b1;
        wait_clk(32);
        check("break_busy_dropped", 32'(busy), 32'd0);
        check("ferr_q_out_held", 32'(q_out), 32'hA5);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1, 16);
        wait_clk(32);

        // back-to-back 0x00 then 0xFF
        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        wait_clk(32);
        check("b2b_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'd160);

        // reset in the middle of data bit 4 of 0x5A; line then held idle
        s_in = 1'b0;
        wait_clk(16);
        for (int i = 7; i >= 4; i--) begin
            s_in = (i == 6 || i == 4) ? 1'b1 : 1'b0;
            wait_clk(16);
        end
        s_in = 1'b1;
        wait_clk(8);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_q_out", 32'(q_out), 32'h00);
        wait_clk(200);
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1, 16);
        wait_clk(32);

        // clk_en on every third clk, 48 clk per bit
        gate_en = 1'b1;
        wait_clk(30);
        expect_byte(8'hC3);
        send_frame(8'hC3, 1'b1, 48);
        wait_clk(96);
        gate_en = 1'b0;
        wait_clk(10);
        check("gated_q_out", 32'(q_out), 32'hC3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receive block: the receive end of the team's 10-bit serial frame (start bit 0, eight data bits MSB first, stop bit 1), the counterpart of the UART transmit block. It synchronises the asynchronous serial line and oversamples it on a clock-enable tick. It presents each good byte on a parallel bus with a one-clock valid pulse, and flags bad stop bits. It sits between the board RX pin and the consuming logic, sharing the system clock with the transmitter.

## Interface
- OVERSAMPLE, 16, clk_en ticks per bit period; even, ≥4; sample point is mid-bit.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clk_en  input  1  oversample tick, OVERSAMPLE × baud rate; all bit timing advances only on cycles with clk_en=1.
- s_in  input  1  asynchronous serial line, idle high.
- q_out  output  8  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-clk pulse: q_out updated this cycle.
- frame_err  output  1  one-clk pulse: stop bit sampled as 0; q_out not updated.
- busy  output  1  high in any state except IDLE.

## Operation
- s_in passes through a 2-flop synchroniser (s_sync). Both flops reset to 1 and clock every clk, independent of clk_en.
- The state machine has states IDLE, START, DATA, STOP and BREAK. tick_cnt and bit_cnt change only on clk_en cycles.
- IDLE: on a tick with s_sync=0 → START, tick_cnt←0.
- START: each tick tick_cnt++. On the OVERSAMPLE/2-th tick after detection (mid start bit):
  - if s_sync=0 → DATA, tick_cnt←0, bit_cnt←0;
  - else this is a glitch → IDLE with no output activity.
- DATA: each tick tick_cnt++. On the OVERSAMPLE-th tick after entry or the previous sample:
  - shift_reg←{shift_reg[6:0], s_sync}, tick_cnt←0, bit_cnt++;
  - after the 8th sample → STOP.
  - The first received bit lands in q_out[7] (MSB first).
- STOP: on the OVERSAMPLE-th tick:
  - if s_sync=1 → q_out←shift_reg, valid←1, → IDLE;
  - if s_sync=0 → frame_err←1, → BREAK.
- BREAK: wait for a tick with s_sync=1, then → IDLE. A held-low line (break) therefore produces exactly one frame_err and no repeated frames.
- valid and frame_err are registered and are cleared on the next clk regardless of clk_en. They are never high together.
- No receive buffer. The consumer must take q_out on valid; the next good frame overwrites it.

## Timing
- Reset values: q_out=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, synchroniser=1,1.
- Reset mid-frame: return to IDLE on the next clk edge. The partial byte is discarded and no valid or frame_err is produced.
- Synchroniser latency: 2 clk from s_in to s_sync.
- Sample points, counted in ticks after the detection tick:
  - start bit: OVERSAMPLE/2;
  - data bit n (n=0..7): OVERSAMPLE/2 + (n+1)·OVERSAMPLE;
  - stop bit: OVERSAMPLE/2 + 9·OVERSAMPLE (152 for OVERSAMPLE=16).
- valid / frame_err are high for the one clk cycle immediately after the edge on which the stop sample occurs.
- busy rises the clk after the detection tick. It falls the clk after the stop sample on a good frame, or after BREAK exits.
- Back-to-back frames: a start bit immediately following the stop bit is detected. IDLE is entered at mid-stop, leaving half a bit of margin.
- clk_en=0: state, tick_cnt and bit_cnt are frozen; the synchroniser keeps running.
- Tolerance: mid-bit sampling accepts up to ±(OVERSAMPLE/2−1)/OVERSAMPLE bit of accumulated drift at the stop bit.

## Test plan
All scenarios use OVERSAMPLE=16 and clk_en=1 every clk unless noted; one bit = 16 clk.
- Single frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) → one valid pulse with q_out=8'hA5 at clk 152+2 after the falling edge (±1 for detection alignment); frame_err never asserted.
- Glitch: s_in low for 4 clk, then high → busy pulses then drops at the mid-start check; no valid; q_out unchanged.
- Framing error: frame 0x3C with stop=0, line held low 40 bit-times, then high → exactly one frame_err pulse; q_out keeps its previous value; busy stays 1 until the line returns high; a following 0x81 frame is received correctly.
- Back-to-back: 0x00 then 0xFF with no idle gap → two valid pulses, 160 clk apart, with q_out=8'h00 then 8'hFF.
- Reset mid-frame: assert rst for 1 clk at data bit 4 of 0x5A → busy=0 and q_out=8'h00 the next clk; no valid for that frame; the next 0x5A frame is received correctly.
- Enable gating: clk_en on every 3rd clk, bit = 48 clk, frame 0xC3 → q_out=8'hC3 with one valid; valid width is still 1 clk.
